// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings
// and the default operand width.
package serial_add_ctrl_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder assembled from two half adders and an OR gate.
module serial_fa_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic co
);

   logic s1, c1, c2;

   assign s1 = x ^ y;
   assign c1 = x & y;
   assign s  = s1 ^ cin;
   assign c2 = s1 & cin;
   assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: latches an operand pair, steps one full-adder
// cell LSB first with a registered carry, and pulses done with the result.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);
   // Terminal count is WIDTH-1 so the counter never wraps, even for WIDTH=1.
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, next;
   logic             load, step;
   logic [WIDTH-1:0] sa, sb, res;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s, co;
   logic [WIDTH:0]   res_cat;
   logic [WIDTH-1:0] res_next;

   serial_fa_cell u_cell (
      .x   (sa[0]),
      .y   (sb[0]),
      .cin (carry),
      .s   (s),
      .co  (co)
   );

   // New sum bit enters at the MSB; widening first keeps WIDTH=1 legal.
   assign res_cat  = {s, res};
   assign res_next = res_cat[WIDTH:1];

   always_comb begin
      next = IDLE;
      load = 1'b0;
      step = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next = RUN;
               load = 1'b1;
            end
         end
         RUN: begin
            step = 1'b1;
            next = (cnt == LAST) ? DONE : RUN;
         end
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sa    <= '0;
         sb    <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= next;
         busy  <= (next == RUN) || (next == DONE);
         done  <= (next == DONE);
         if (load) begin
            sa    <= a;
            sb    <= b;
            carry <= 1'b0;
            cnt   <= '0;
         end else if (step) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= co;
            cnt   <= cnt + CW'(1);
            res   <= res_next;
            if (cnt == LAST) begin
               sum  <= res_next;
               cout <= co;
            end
         end
      end
   end

endmodule
